comparator_pulse_sequencer: RTL and testbench

Parametrised burst pulser and error checker for the comparator test path. On a fire request it drives `pulse_en` for a programmable width, waits a programmable BX delay, and samples the halfstrip and comparator outputs against expected values. It repeats this for N pulses per request, keeps saturating per-readout and per-bit error counters, and captures the first halfstrip mismatch mask. It sits between the host register interface and the pulse DAC / comparator readout.

---
 rtl/comparator_pulse_sequencer_if.sv | 49 ++++
 rtl/comparator_pulse_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_comparator_pulse_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_pulse_sequencer_if.sv
// Signal bundle between the host register block, the pulse DAC and the comparator readout.
// Handshake: fire_pulse is a request taken only on a cycle with pulser_ready=1 and abort=0; a request seen while busy is dropped, never queued.
interface comparator_pulse_sequencer_if #(
    parameter int NSTRIPS = 32,
    parameter int CNT_W   = 32,
    parameter int BX_W    = 4,
    parameter int NP_W    = 8
);
    logic               fire_pulse;
    logic               abort;
    logic [NP_W-1:0]    n_pulses;
    logic [BX_W-1:0]    pulse_width;
    logic [BX_W-1:0]    bx_delay;
    logic [NSTRIPS-1:0] halfstrips;
    logic [NSTRIPS-1:0] halfstrips_expect;
    logic               compout;
    logic               compout_expect;
    logic               halfstrips_errcnt_rst;
    logic               compout_errcnt_rst;

    logic               pulse_en;
    logic               pulser_ready;
    logic               readout_strobe;
    logic [NP_W-1:0]    pulse_cnt;
    logic [CNT_W-1:0]   halfstrips_errcnt;
    logic [CNT_W-1:0]   halfstrips_biterr;
    logic [CNT_W-1:0]   compout_errcnt;
    logic [NSTRIPS-1:0] first_err_mask;
    logic               err_flag;
    logic [1:0]         dbg_state;

    modport master (
        output fire_pulse, abort, n_pulses, pulse_width, bx_delay,
               halfstrips, halfstrips_expect, compout, compout_expect,
               halfstrips_errcnt_rst, compout_errcnt_rst,
        input  pulse_en, pulser_ready, readout_strobe, pulse_cnt,
               halfstrips_errcnt, halfstrips_biterr, compout_errcnt,
               first_err_mask, err_flag, dbg_state
    );

    modport slave (
        input  fire_pulse, abort, n_pulses, pulse_width, bx_delay,
               halfstrips, halfstrips_expect, compout, compout_expect,
               halfstrips_errcnt_rst, compout_errcnt_rst,
        output pulse_en, pulser_ready, readout_strobe, pulse_cnt,
               halfstrips_errcnt, halfstrips_biterr, compout_errcnt,
               first_err_mask, err_flag, dbg_state
    );
endinterface

// File: rtl/comparator_pulse_sequencer.sv
// Burst pulser: drives pulse_en for PW cycles, waits BD cycles, then compares halfstrip/comparator data.
// Repeats for N pulses per fire and keeps saturating error counters plus the first halfstrip mismatch mask.
module comparator_pulse_sequencer #(
    parameter int NSTRIPS = 32,
    parameter int CNT_W   = 32,
    parameter int BX_W    = 4,
    parameter int NP_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    comparator_pulse_sequencer_if.slave bus
);
    localparam int PC_W  = $clog2(NSTRIPS + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PULSE_ON  = 2'd1,
        S_PULSE_OFF = 2'd2,
        S_READOUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BX_W-1:0]    r_bx_cnt;
    logic [BX_W-1:0]    w_bx_cnt_next;
    logic [BX_W-1:0]    r_pw;
    logic [BX_W-1:0]    r_bd;
    logic [NP_W-1:0]    r_np;
    logic [NP_W-1:0]    r_pulse_cnt;
    logic [NP_W-1:0]    w_pulse_cnt_next;
    logic [NP_W-1:0]    w_cnt_inc;
    logic               w_fire;
    logic               w_compare;
    logic               r_pulse_en;

    logic [NSTRIPS-1:0] w_xor;
    logic               w_hs_mis;
    logic               w_co_mis;
    logic [PC_W-1:0]    w_popcnt;
    logic [SUM_W-1:0]   w_bit_sum;

    logic [CNT_W-1:0]   r_hs_errcnt;
    logic [CNT_W-1:0]   r_hs_biterr;
    logic [CNT_W-1:0]   r_co_errcnt;
    logic [NSTRIPS-1:0] r_first_mask;
    logic               r_err_flag;

    // Next-state logic; abort overrides every transition and suppresses the readout side effects.
    always_comb begin
        w_next           = r_state;
        w_bx_cnt_next    = r_bx_cnt;
        w_pulse_cnt_next = r_pulse_cnt;
        w_fire           = 1'b0;
        w_compare        = 1'b0;
        w_cnt_inc        = r_pulse_cnt + NP_W'(1);
        case (r_state)
            S_IDLE: begin
                if (bus.fire_pulse) begin
                    w_next           = S_PULSE_ON;
                    w_fire           = 1'b1;
                    w_bx_cnt_next    = '0;
                    w_pulse_cnt_next = '0;
                end
            end
            S_PULSE_ON: begin
                if (r_bx_cnt == r_pw - BX_W'(1)) begin
                    w_bx_cnt_next = '0;
                    w_next        = (r_bd == '0) ? S_READOUT : S_PULSE_OFF;
                end else begin
                    w_bx_cnt_next = r_bx_cnt + BX_W'(1);
                end
            end
            S_PULSE_OFF: begin
                if (r_bx_cnt == r_bd - BX_W'(1)) begin
                    w_bx_cnt_next = '0;
                    w_next        = S_READOUT;
                end else begin
                    w_bx_cnt_next = r_bx_cnt + BX_W'(1);
                end
            end
            S_READOUT: begin
                w_compare        = 1'b1;
                w_pulse_cnt_next = w_cnt_inc;
                w_bx_cnt_next    = '0;
                w_next           = (w_cnt_inc < r_np) ? S_PULSE_ON : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (bus.abort) begin
            w_next           = S_IDLE;
            w_fire           = 1'b0;
            w_compare        = 1'b0;
            w_bx_cnt_next    = '0;
            w_pulse_cnt_next = r_pulse_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bx_cnt    <= '0;
            r_pulse_cnt <= '0;
            r_pulse_en  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_bx_cnt    <= w_bx_cnt_next;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_pulse_en  <= (w_next == S_PULSE_ON);
        end
    end

    // Burst parameters are frozen at the accepted fire so host writes mid-burst are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pw <= BX_W'(1);
            r_bd <= '0;
            r_np <= NP_W'(1);
        end else if (w_fire) begin
            r_pw <= (bus.pulse_width == '0) ? BX_W'(1) : bus.pulse_width;
            r_bd <= bus.bx_delay;
            r_np <= (bus.n_pulses == '0) ? NP_W'(1) : bus.n_pulses;
        end
    end

    assign w_xor     = bus.halfstrips ^ bus.halfstrips_expect;
    assign w_hs_mis  = |w_xor;
    assign w_co_mis  = bus.compout ^ bus.compout_expect;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NSTRIPS; i++) begin
            w_popcnt = w_popcnt + PC_W'(w_xor[i]);
        end
    end

    // Extra headroom bit(s) catch the carry so the bit-error total clamps instead of wrapping.
    assign w_bit_sum = SUM_W'(r_hs_biterr) + SUM_W'(w_popcnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_errcnt  <= '0;
            r_hs_biterr  <= '0;
            r_first_mask <= '0;
            r_err_flag   <= 1'b0;
        end else if (bus.halfstrips_errcnt_rst) begin
            r_hs_errcnt  <= '0;
            r_hs_biterr  <= '0;
            r_first_mask <= '0;
            r_err_flag   <= 1'b0;
        end else if (w_compare && w_hs_mis) begin
            if (r_hs_errcnt != '1) begin
                r_hs_errcnt <= r_hs_errcnt + CNT_W'(1);
            end
            r_hs_biterr <= (|w_bit_sum[SUM_W-1:CNT_W]) ? '1 : w_bit_sum[CNT_W-1:0];
            if (!r_err_flag) begin
                r_first_mask <= w_xor;
            end
            r_err_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_co_errcnt <= '0;
        end else if (bus.compout_errcnt_rst) begin
            r_co_errcnt <= '0;
        end else if (w_compare && w_co_mis && (r_co_errcnt != '1)) begin
            r_co_errcnt <= r_co_errcnt + CNT_W'(1);
        end
    end

    assign bus.pulse_en          = r_pulse_en;
    assign bus.pulser_ready      = (r_state == S_IDLE);
    assign bus.readout_strobe    = (r_state == S_READOUT);
    assign bus.pulse_cnt         = r_pulse_cnt;
    assign bus.halfstrips_errcnt = r_hs_errcnt;
    assign bus.halfstrips_biterr = r_hs_biterr;
    assign bus.compout_errcnt    = r_co_errcnt;
    assign bus.first_err_mask    = r_first_mask;
    assign bus.err_flag          = r_err_flag;
    assign bus.dbg_state         = r_state;
endmodule

// File: tb/tb_comparator_pulse_sequencer.sv
// Bench for comparator_pulse_sequencer: vector table, hand-written corner sequences and random bursts
// checked against a timeline/counter model computed from burst arithmetic.
module tb_comparator_pulse_sequencer;
    localparam int NSTRIPS = 32;
    localparam int CNT_W   = 4;
    localparam int BX_W    = 4;
    localparam int NP_W    = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    comparator_pulse_sequencer_if #(
        .NSTRIPS(NSTRIPS), .CNT_W(CNT_W), .BX_W(BX_W), .NP_W(NP_W)
    ) bus ();

    comparator_pulse_sequencer #(
        .NSTRIPS(NSTRIPS), .CNT_W(CNT_W), .BX_W(BX_W), .NP_W(NP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required test completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    int          m_errcnt;
    int          m_biterr;
    int          m_cerr;
    logic [31:0] m_first;
    logic        m_flag;

    typedef struct {
        int          n;
        int          pw;
        int          bd;
        int          mode;
        int          e_err;
        int          e_bit;
        int          e_cerr;
        logic [31:0] e_first;
        logic        e_flag;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_clear();
        m_errcnt = 0;
        m_biterr = 0;
        m_cerr   = 0;
        m_first  = '0;
        m_flag   = 1'b0;
    endtask

    task automatic model_readout(input logic [31:0] x, input logic cm);
        if (x != 0) begin
            if (!m_flag) m_first = x;
            m_flag   = 1'b1;
            m_errcnt = sat(m_errcnt + 1);
            m_biterr = sat(m_biterr + $countones(x));
        end
        if (cm) m_cerr = sat(m_cerr + 1);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_hs_errcnt"}, bus.halfstrips_errcnt, m_errcnt);
        chk({tag, "_hs_biterr"}, bus.halfstrips_biterr, m_biterr);
        chk({tag, "_co_errcnt"}, bus.compout_errcnt, m_cerr);
        chk({tag, "_first_mask"}, bus.first_err_mask, m_first);
        chk({tag, "_err_flag"}, bus.err_flag, m_flag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.pulser_ready, 1);
        chk({tag, "_pulse_en"}, bus.pulse_en, 0);
        chk({tag, "_strobe"}, bus.readout_strobe, 0);
        chk({tag, "_pulse_cnt"}, bus.pulse_cnt, 0);
        chk({tag, "_hs_errcnt"}, bus.halfstrips_errcnt, 0);
        chk({tag, "_hs_biterr"}, bus.halfstrips_biterr, 0);
        chk({tag, "_co_errcnt"}, bus.compout_errcnt, 0);
        chk({tag, "_first_mask"}, bus.first_err_mask, 0);
        chk({tag, "_err_flag"}, bus.err_flag, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.fire_pulse            = 1'b0;
        bus.abort                 = 1'b0;
        bus.n_pulses              = '0;
        bus.pulse_width           = '0;
        bus.bx_delay              = '0;
        bus.halfstrips            = '0;
        bus.halfstrips_expect     = '0;
        bus.compout               = 1'b0;
        bus.compout_expect        = 1'b0;
        bus.halfstrips_errcnt_rst = 1'b0;
        bus.compout_errcnt_rst    = 1'b0;
    endtask

    task automatic clear_counters();
        bus.halfstrips_errcnt_rst = 1'b1;
        bus.compout_errcnt_rst    = 1'b1;
        step();
        bus.halfstrips_errcnt_rst = 1'b0;
        bus.compout_errcnt_rst    = 1'b0;
        model_clear();
    endtask

    task automatic set_data(input logic [31:0] x, input logic cm);
        bus.halfstrips_expect = $urandom();
        bus.halfstrips        = bus.halfstrips_expect ^ x;
        bus.compout_expect    = 1'($urandom_range(0, 1));
        bus.compout           = bus.compout_expect ^ cm;
    endtask

    task automatic make_data(input int mode, input int r, output logic [31:0] x, output logic cm);
        x  = '0;
        cm = 1'b0;
        case (mode)
            1: x = (r == 2 || r == 4) ? 32'h5 : 32'h0;
            2: begin
                case ($urandom_range(0, 3))
                    2:       x = 32'h1 << $urandom_range(0, 31);
                    3:       x = $urandom();
                    default: x = '0;
                endcase
                cm = 1'($urandom_range(0, 1));
            end
            3: cm = 1'b1;
            4: x = 32'hFF;
            5: begin
                x  = 32'h3;
                cm = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Fires one burst and walks it cycle by cycle against the arithmetic timeline.
    task automatic run_burst(input int n_raw, input int pw_raw, input int bd_raw, input int mode);
        int n, pw, bd, len, tot, r;
        logic [31:0] x;
        logic        cm;
        logic [15:0] got;
        n   = (n_raw == 0) ? 1 : n_raw;
        pw  = (pw_raw == 0) ? 1 : pw_raw;
        bd  = bd_raw;
        len = pw + bd + 1;
        tot = n * len;
        exp_q.delete();
        for (int p = 1; p <= n; p++) exp_q.push_back(16'(p * len));
        bus.n_pulses    = NP_W'(n_raw);
        bus.pulse_width = BX_W'(pw_raw);
        bus.bx_delay    = BX_W'(bd_raw);
        bus.fire_pulse  = 1'b1;
        step();
        bus.fire_pulse  = 1'b0;
        bus.n_pulses    = NP_W'($urandom());
        bus.pulse_width = BX_W'($urandom());
        bus.bx_delay    = BX_W'($urandom());
        r = 0;
        for (int c = 1; c <= tot; c++) begin
            int ph;
            ph = (c - 1) % len;
            chk("burst_pulse_en", bus.pulse_en, ph < pw);
            chk("burst_strobe", bus.readout_strobe, ph == len - 1);
            chk("burst_ready", bus.pulser_ready, 0);
            chk("burst_pulse_cnt", bus.pulse_cnt, (c - 1) / len);
            if (bus.readout_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    chk("strobe_cycle", c, got);
                end
            end
            if (ph == len - 1) begin
                r++;
                make_data(mode, r, x, cm);
                model_readout(x, cm);
            end else begin
                x  = $urandom() | 32'h1;
                cm = 1'b1;
            end
            set_data(x, cm);
            step();
        end
        chk("end_ready", bus.pulser_ready, 1);
        chk("end_pulse_en", bus.pulse_en, 0);
        chk("end_strobe", bus.readout_strobe, 0);
        chk("end_pulse_cnt", bus.pulse_cnt, n);
        chk("end_strobes_left", exp_q.size(), 0);
        check_counters("end");
    endtask

    // ---------------- test ----------------
    initial begin
        int strobes;
        vecs[0] = '{n: 1,  pw: 3,  bd: 2,  mode: 0, e_err: 0, e_bit: 0,  e_cerr: 0,  e_first: 32'h0,  e_flag: 1'b0};
        vecs[1] = '{n: 4,  pw: 0,  bd: 0,  mode: 1, e_err: 2, e_bit: 4,  e_cerr: 0,  e_first: 32'h5,  e_flag: 1'b1};
        vecs[2] = '{n: 20, pw: 1,  bd: 0,  mode: 3, e_err: 0, e_bit: 0,  e_cerr: 15, e_first: 32'h0,  e_flag: 1'b0};
        vecs[3] = '{n: 0,  pw: 0,  bd: 3,  mode: 0, e_err: 0, e_bit: 0,  e_cerr: 0,  e_first: 32'h0,  e_flag: 1'b0};
        vecs[4] = '{n: 3,  pw: 15, bd: 15, mode: 1, e_err: 1, e_bit: 2,  e_cerr: 0,  e_first: 32'h5,  e_flag: 1'b1};
        vecs[5] = '{n: 6,  pw: 2,  bd: 1,  mode: 1, e_err: 2, e_bit: 4,  e_cerr: 0,  e_first: 32'h5,  e_flag: 1'b1};
        vecs[6] = '{n: 3,  pw: 1,  bd: 1,  mode: 4, e_err: 3, e_bit: 15, e_cerr: 0,  e_first: 32'hFF, e_flag: 1'b1};

        drive_idle();
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        step();
        check_reset_vals("after_reset");

        // Table of fixed bursts.
        foreach (vecs[i]) begin
            clear_counters();
            run_burst(vecs[i].n, vecs[i].pw, vecs[i].bd, vecs[i].mode);
            chk("tbl_hs_errcnt", bus.halfstrips_errcnt, vecs[i].e_err);
            chk("tbl_hs_biterr", bus.halfstrips_biterr, vecs[i].e_bit);
            chk("tbl_co_errcnt", bus.compout_errcnt, vecs[i].e_cerr);
            chk("tbl_first_mask", bus.first_err_mask, vecs[i].e_first);
            chk("tbl_err_flag", bus.err_flag, vecs[i].e_flag);
        end

        // Clears win over a same-cycle readout increment.
        clear_counters();
        run_burst(2, 1, 0, 5);
        bus.n_pulses    = 8'd1;
        bus.pulse_width = 4'd1;
        bus.bx_delay    = 4'd0;
        bus.fire_pulse  = 1'b1;
        step();
        bus.fire_pulse = 1'b0;
        set_data(32'h0, 1'b0);
        step();
        chk("clr_strobe", bus.readout_strobe, 1);
        set_data(32'h3, 1'b1);
        bus.halfstrips_errcnt_rst = 1'b1;
        bus.compout_errcnt_rst    = 1'b1;
        step();
        bus.halfstrips_errcnt_rst = 1'b0;
        bus.compout_errcnt_rst    = 1'b0;
        model_clear();
        chk("clr_pulse_cnt", bus.pulse_cnt, 1);
        check_counters("clr_wins");

        // Abort in PULSE_OFF of pulse 2 with fire_pulse held through the burst.
        set_data(32'h0, 1'b0);
        bus.halfstrips  = bus.halfstrips_expect;
        bus.n_pulses    = 8'd5;
        bus.pulse_width = 4'd2;
        bus.bx_delay    = 4'd2;
        bus.fire_pulse  = 1'b1;
        step();
        strobes = 0;
        for (int c = 1; c <= 7; c++) begin
            if (bus.readout_strobe) strobes++;
            chk("abort_busy_ready", bus.pulser_ready, 0);
            step();
        end
        chk("abort_pre_strobes", strobes, 1);
        chk("abort_pre_pulse_cnt", bus.pulse_cnt, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_idle_ready", bus.pulser_ready, 1);
        chk("abort_pulse_en", bus.pulse_en, 0);
        chk("abort_no_strobe", bus.readout_strobe, 0);
        chk("abort_pulse_cnt", bus.pulse_cnt, 1);
        step();
        chk("refire_ready", bus.pulser_ready, 0);
        chk("refire_pulse_en", bus.pulse_en, 1);
        chk("refire_pulse_cnt", bus.pulse_cnt, 0);
        bus.fire_pulse = 1'b0;
        bus.abort      = 1'b1;
        step();
        chk("abort2_ready", bus.pulser_ready, 1);
        bus.fire_pulse = 1'b1;
        step();
        bus.fire_pulse = 1'b0;
        bus.abort      = 1'b0;
        chk("abort_over_fire_ready", bus.pulser_ready, 1);
        chk("abort_over_fire_pulse_en", bus.pulse_en, 0);
        check_counters("abort");

        // Asynchronous reset while pulse_en is high.
        run_burst(1, 1, 0, 5);
        bus.n_pulses    = 8'd3;
        bus.pulse_width = 4'd4;
        bus.bx_delay    = 4'd1;
        bus.fire_pulse  = 1'b1;
        step();
        bus.fire_pulse = 1'b0;
        step();
        chk("rst_pre_pulse_en", bus.pulse_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pulse_en", bus.pulse_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        step();
        check_reset_vals("rst_mid_burst");

        // Random bursts against the model.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) clear_counters();
            repeat ($urandom_range(0, 2)) step();
            run_burst($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
